// File: rtl/serial_tx_pkg.sv
// Shared types and line levels for the serial_tx framed transmitter.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1 on enabled cycles and
// flags the last cycle of each serial bit.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_n,
  input  logic restart,
  output logic bit_done
);

  // Keep at least one counter bit so CLKS_PER_BIT=1 still elaborates.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign bit_done = (r_cnt == LAST) && !en_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!en_n) begin
      if (restart || (r_cnt == LAST)) r_cnt <= '0;
      else                            r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Framed parallel-in/serial-out transmitter, LSB first, idle-high line.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              busy
);

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_shift;
  logic [BC_W-1:0]   r_bit_cnt;
  logic              r_tx_line;
  logic              w_level;
  logic              w_bit_done;
  logic              w_accept;
`ifdef SERIAL_TX_PARITY_EN
  logic              r_parity;
`endif

  assign w_accept = (r_state == IDLE) && tx_valid && !en_n;
  assign tx_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);
  assign tx_line  = r_tx_line;

  // The timer is held at zero while idle so every frame starts on a fresh bit.
  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .en_n    (en_n),
    .restart (r_state == IDLE),
    .bit_done(w_bit_done)
  );

  always_ff @(posedge clk) begin
    if (rst)        r_state <= IDLE;
    else if (!en_n) r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_level = IDLE_LEVEL;
    case (r_state)
      IDLE: begin
        w_level = IDLE_LEVEL;
        if (tx_valid) w_next = START;
      end
      START: begin
        w_level = START_LEVEL;
        if (w_bit_done) w_next = DATA;
      end
      DATA: begin
        w_level = r_shift[0];
        if (w_bit_done && (r_bit_cnt == LAST_BIT)) begin
`ifdef SERIAL_TX_PARITY_EN
          w_next = PARITY;
`else
          w_next = STOP;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        w_level = r_parity;
        if (w_bit_done) w_next = STOP;
      end
`endif
      STOP: begin
        w_level = STOP_LEVEL;
        if (w_bit_done) w_next = IDLE;
      end
      default: begin
        w_next  = IDLE;
        w_level = IDLE_LEVEL;
      end
    endcase
  end

  // The line register follows the current state, so it lags state by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx_line <= IDLE_LEVEL;
`ifdef SERIAL_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (!en_n) begin
      r_tx_line <= w_level;
      if (w_accept) begin
        r_shift   <= tx_data;
        r_bit_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
        r_parity  <= ^tx_data;
`endif
      end else if ((r_state == DATA) && w_bit_done) begin
        r_shift   <= r_shift >> 1;
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed self-checking bench for serial_tx; expected line bits are queued
// when a word is sent and popped as the line is sampled on negedges.
module tb_serial_tx;

  localparam int DATA_W = 8;
  localparam int CPB    = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = DATA_W + 3;
`else
  localparam int NB = DATA_W + 2;
`endif

  logic              clk;
  logic              rst;
  logic              en_n;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              tx_line;
  logic              busy;

  int n_cmp  = 0;
  int n_fail = 0;
  bit exp_q[$];

  serial_tx #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en_n    (en_n),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .tx_line (tx_line),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [DATA_W-1:0] w);
    exp_q.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) exp_q.push_back(w[i]);
`ifdef SERIAL_TX_PARITY_EN
    exp_q.push_back(^w);
`endif
    exp_q.push_back(1'b1);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
  task automatic send(input logic [DATA_W-1:0] w);
    push_frame(w);
    tx_valid = 1'b1;
    tx_data  = w;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("latency_line", tx_line, 1);
    chk("accept_busy", busy, 1);
    chk("accept_ready", tx_ready, 0);
  endtask

  // Checks n queued bits; bit sidx gets en_n=1 for 3 cycles mid-bit.
  task automatic check_bits(input int n, input int sidx);
    bit b;
    int len;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        chk("queue_underflow", 1, 0);
        return;
      end
      b   = exp_q.pop_front();
      len = (i == sidx) ? CPB + 3 : CPB;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        chk($sformatf("line_b%0d_c%0d", i, c), tx_line, b);
        if (i < NB - 1) chk($sformatf("ready_low_b%0d", i), tx_ready, 0);
        if (i == sidx && c == 1) en_n = 1'b1;
        if (i == sidx && c == 4) en_n = 1'b0;
      end
    end
  endtask

  task automatic finish_idle();
    @(negedge clk);
    chk("idle_line", tx_line, 1);
    chk("idle_ready", tx_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  task automatic tx_frame(input logic [DATA_W-1:0] w, input int sidx);
    send(w);
    check_bits(NB, sidx);
    finish_idle();
  endtask

  task automatic reset_mid(input logic en_val);
    bit b;
    send(8'h00);
    check_bits(6, -1);
    @(negedge clk);
    b = exp_q.pop_front();
    chk("mid_bit5", tx_line, b);
    rst  = 1'b1;
    en_n = en_val;
    @(negedge clk);
    chk("rst_mid_line", tx_line, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", tx_ready, 1);
    rst  = 1'b0;
    en_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    tx_frame(8'h5A, -1);
  endtask

  initial begin
    rst      = 1'b1;
    en_n     = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_line", tx_line, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst  = 1'b0;
    en_n = 1'b0;
    @(negedge clk);

    // Transfer must be ignored while disabled.
    en_n     = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      chk("dis_ready", tx_ready, 1);
      chk("dis_busy", busy, 0);
      chk("dis_line", tx_line, 1);
    end
    tx_valid = 1'b0;
    en_n     = 1'b0;
    @(negedge clk);

    tx_frame(8'hA5, -1);
    tx_frame(8'h01, -1);

    // Back-to-back with tx_valid held high.
    push_frame(8'h3C);
    push_frame(8'hC3);
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    tx_data = 8'hC3;
    chk("b2b_latency", tx_line, 1);
    check_bits(NB, -1);
    @(negedge clk);
    chk("b2b_gap_line", tx_line, 1);
    chk("b2b_gap_busy", busy, 1);
    tx_valid = 1'b0;
    check_bits(NB, -1);
    finish_idle();

    // Data bit 2 is frame bit 3.
    tx_frame(8'h96, 3);

    reset_mid(1'b0);
    reset_mid(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-in, serial-out framed transmitter that drives a single-bit line sampled by the lab's D flip-flop-based receivers.
- Accepts a DATA_W-bit word via valid/ready and shifts it out LSB first.
- Frame: one start bit (0), DATA_W data bits, optional parity bit, one stop bit (1).
- Each bit is held for CLKS_PER_BIT enabled clock cycles. The line idles high.

Parameters:
- DATA_W, 8, payload width in bits (≥1).
- CLKS_PER_BIT, 4, enabled clock cycles per serial bit (≥1).

Ports:
- clk  input  1  system clock, all state updates on posedge clk.
- rst  input  1  synchronous reset, active-high.
- en_n  input  1  active-low clock enable; when 1, all state, counters and outputs hold.
- tx_valid  input  1  tx_data valid for transfer.
- tx_data  input  DATA_W  word to send.
- tx_ready  output  1  block can accept a word this cycle.
- tx_line  output  1  serial output, registered.
- busy  output  1  frame in progress (state != IDLE).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst), sampled on posedge clk.
  - rst has priority over en_n and applies even when en_n=1.
- Reset values: state=IDLE, tx_line=1, tx_ready=1, busy=0, shift register=0, bit counter=0, cycle counter=0.
- Enable: with en_n=1 nothing changes and no handshake completes. tx_ready still reflects state, but the transfer is ignored while en_n=1.
- Handshake: transfer occurs on a posedge with en_n=0, state=IDLE and tx_valid=1.
  - tx_ready = (state==IDLE), combinational from state only.
  - tx_data is captured into the shift register at that edge.
  - tx_valid/tx_data are ignored outside IDLE.
- States:
  - IDLE: tx_line=1. On transfer → START.
  - START: tx_line=0 for CLKS_PER_BIT enabled cycles → DATA.
  - DATA: tx_line=shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit counter. After DATA_W bits → PARITY if enabled, else STOP.
  - PARITY: tx_line=parity bit for CLKS_PER_BIT cycles → STOP.
  - STOP: tx_line=1 for CLKS_PER_BIT cycles → IDLE.
- Latency: tx_line falls on the first posedge after the accepting edge (registered output).
- Frame length: (DATA_W+2) × CLKS_PER_BIT enabled cycles, plus CLKS_PER_BIT if parity is compiled in.
- Back-to-back: after STOP ends, the block spends at least one IDLE cycle (line high, tx_ready=1) before the next start bit.
- Cycle counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. CLKS_PER_BIT=1 gives one cycle per bit.
- Bit counter width: $clog2(DATA_W+1). Wraps cleanly; no overflow is reachable.
- Reset mid-frame: returns to IDLE on that edge and tx_line=1 on that edge. The partial frame is abandoned and no word is retained.
- Enable deasserted mid-bit: the bit is stretched by the number of disabled cycles; the frame resumes unchanged.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined: PARITY state is present and emits even parity, i.e. XOR of the captured word, computed at capture.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Decomposition:
- Package serial_tx_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP.
  - IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1.
- One sub-module, bit_timer: the cycle counter.
  - Inputs: clk, rst, en_n, restart.
  - Output: bit_done, pulsed on the last cycle of each bit.

Test Plan (DATA_W=8, CLKS_PER_BIT=4):
- Reset: assert rst for 2 cycles with en_n=1 → tx_line=1, tx_ready=1, busy=0 after the first edge.
- Send 0xA5, parity off → tx_line sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 cycles (40 cycles total). tx_ready low throughout, high again after the stop bit.
- Send 0xA5 with SERIAL_TX_PARITY_EN → parity bit 0 inserted before stop (44 cycles). Send 0x01 → parity bit 1.
- Hold tx_valid=1 with 0x3C then 0xC3 → two frames separated by exactly one idle-high cycle. Data assertion: 0x3C sends 0,0,1,1,1,1,0,0.
- Drive en_n=1 for 3 cycles in the middle of data bit 2 → that bit lasts 7 clk cycles; the rest of the frame is unchanged.
- Assert rst during data bit 5 (en_n=0 and en_n=1 cases) → next edge: tx_line=1, busy=0, tx_ready=1. A new send of 0x5A then transmits correctly.
